rom_loader: RTL and testbench

- Firmware writer for the instruction ROM. It is the write-side counterpart of the core's read-only fetch port.
- It accepts a byte stream from a serial receiver over a valid/ready handshake, then packs the bytes little-endian into 32-bit words and writes them sequentially into the ROM write port.
- While loading it holds the core in reset with enable low. It releases the core only after a complete, well-formed image has been written.

---
 rtl/rom_loader_pkg.sv | 41 ++++
 rtl/rom_loader_if.sv | 39 +++
 rtl/rom_loader_word_packer.sv | 50 +++++
 rtl/rom_loader.sv | 205 ++++++++++++++++++++
 tb/tb_rom_loader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_pkg
//  Description : Shared types and constants for the instruction-ROM loader:
//                loader state encoding, image framing constants and helpers
//                that size the word-index and timeout counters.
//  Revision    : 1.0  initial release
// ============================================================================
package rom_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    // Image framing: 2-byte little-endian word count, then 4 bytes per word.
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    // Default counter widths for the default ROM depth / timeout.
    localparam int IDX_W_DEF = $clog2(1024 + 1);
    localparam int TMO_W_DEF = $clog2(1000000 + 1);

    // The index must be able to hold ROM_WORDS itself (count after last write).
    function automatic int idx_width(input int words);
        return $clog2(words + 1);
    endfunction

    // The timeout counter steps one past its terminal count on the error edge.
    function automatic int tmo_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : rom_loader_pkg
`default_nettype wire

// File: rtl/rom_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_if
//  Description : Byte-stream handshake and ROM write port bundled together.
//                master : the loader (consumes bytes, drives the ROM port)
//                slave  : the environment (serial receiver + ROM)
//  Signals     : byte_data[7:0], byte_valid, byte_ready,
//                rom_we, rom_addr[31:0], rom_wdata[31:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface rom_loader_if;

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        rom_we;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;

    modport master (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output rom_we,
        output rom_addr,
        output rom_wdata
    );

    modport slave (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  rom_we,
        input  rom_addr,
        input  rom_wdata
    );

endinterface : rom_loader_if
`default_nettype wire

// File: rtl/rom_loader_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : word_packer
//  Description : Little-endian byte-to-word assembler. Each strobed byte is
//                inserted into lane `lane` of a 32-bit register. `word` shows
//                the register with the current byte already inserted so the
//                caller can capture a complete word in the same cycle that
//                lane 3 arrives (flagged by word_full).
//  Ports       : clk, reset (async, active-low), clear, strobe, lane, data
//                -> word[31:0], word_full
//  Revision    : 1.0  initial release
// ============================================================================
module word_packer
    import rom_loader_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              clear,
    input  wire logic              strobe,
    input  wire logic [LANE_W-1:0] lane,
    input  wire logic [7:0]        data,
    output logic      [31:0]       word,
    output logic                   word_full
);

    logic [31:0] r_word;
    logic [31:0] w_word;

    always_comb begin
        w_word = r_word;
        if (strobe) begin
            w_word[{lane, 3'b000} +: 8] = data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= 32'd0;
        end else if (clear) begin
            r_word <= 32'd0;
        end else if (strobe) begin
            r_word <= w_word;
        end
    end

    assign word      = w_word;
    assign word_full = strobe && (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule : word_packer
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : Firmware writer for the instruction ROM. Receives an image
//                (2-byte word count L, then 4*L bytes, all LSB first) over a
//                valid/ready byte stream, writes the packed words to
//                consecutive ROM addresses, and releases the core only once a
//                complete, well-formed image has been written.
//  Ports       : clk, reset (async, active-low), start (1-cycle pulse)
//                bus  : rom_loader_if.master (byte stream in, ROM write out)
//                core_reset, core_enable, busy, done, error
//  Revision    : 1.0  initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int          ROM_WORDS      = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       start,
    rom_loader_if.master    bus,
    output logic            core_reset,
    output logic            core_enable,
    output logic            busy,
    output logic            done,
    output logic            error
);

    localparam int          c_idx_w     = idx_width(ROM_WORDS);
    localparam int          c_tmo_w     = tmo_width(TIMEOUT_CYCLES);
    localparam logic [31:0] c_rom_words = 32'(ROM_WORDS);
    localparam logic [63:0] c_last_addr = 64'(BASE_ADDR)
                                        + 64'(BYTES_PER_WORD) * 64'(ROM_WORDS - 1);

    // Parameter legality: the last word address must not wrap 32 bits.
    generate
        if (c_last_addr > 64'h0000_0000_FFFF_FFFF || ROM_WORDS < 1 ||
            ROM_WORDS > 65535 || TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("rom_loader: illegal ROM_WORDS/BASE_ADDR/TIMEOUT_CYCLES");
        end
    endgenerate

    state_t               r_state;
    state_t               w_next;
    logic [15:0]          r_len;
    logic [c_idx_w-1:0]   r_idx;
    logic [LANE_W-1:0]    r_lane;
    logic [c_tmo_w-1:0]   r_tmo;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_strobe;
    logic                 w_clear;
    logic                 w_we;
    logic                 w_tmo_hit;
    logic                 w_last_word;
    logic [15:0]          w_len_full;
    logic [31:0]          w_word;
    logic                 w_word_full;

    // Ready depends only on the registered state, which keeps the accept
    // path free of any loop through the next-state logic.
    assign w_ready     = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
    assign w_accept    = bus.byte_valid && w_ready;
    assign w_strobe    = w_accept && (r_state == DATA);
    assign w_tmo_hit   = (r_tmo == c_tmo_w'(TIMEOUT_CYCLES - 1));
    assign w_len_full  = {bus.byte_data, r_len[7:0]};
    // Compared before the increment: this write is the image's last word.
    assign w_last_word = (32'(r_idx) == (32'(r_len) - 32'd1));

    word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_clear),
        .strobe    (w_strobe),
        .lane      (r_lane),
        .data      (bus.byte_data),
        .word      (w_word),
        .word_full (w_word_full)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_we        = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        core_reset  = 1'b1;
        core_enable = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next  = LEN_LO;
                    w_clear = 1'b1;
                end
            end
            LEN_LO: begin
                busy = 1'b1;
                if (w_accept)       w_next = LEN_HI;
                else if (w_tmo_hit) w_next = ERROR;
            end
            LEN_HI: begin
                busy = 1'b1;
                if (w_accept) begin
                    if (w_len_full == 16'd0 || 32'(w_len_full) > c_rom_words) w_next = ERROR;
                    else                                                       w_next = DATA;
                end else if (w_tmo_hit) begin
                    w_next = ERROR;
                end
            end
            DATA: begin
                busy = 1'b1;
                // An accept in the terminal-count cycle takes priority.
                if (w_accept) begin
                    if (w_word_full) w_next = WRITE;
                end else if (w_tmo_hit) begin
                    w_next = ERROR;
                end
            end
            WRITE: begin
                busy   = 1'b1;
                w_we   = 1'b1;
                w_next = w_last_word ? DONE : DATA;
            end
            DONE: begin
                done        = 1'b1;
                core_reset  = 1'b0;
                core_enable = 1'b1;
                if (start) begin
                    w_next  = LEN_LO;
                    w_clear = 1'b1;
                end
            end
            ERROR: begin
                error = 1'b1;
                if (start) begin
                    w_next  = LEN_LO;
                    w_clear = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------ counters and datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len   <= 16'd0;
            r_idx   <= '0;
            r_lane  <= '0;
            r_tmo   <= '0;
            r_addr  <= BASE_ADDR;
            r_wdata <= 32'd0;
        end else if (w_clear) begin
            r_len  <= 16'd0;
            r_idx  <= '0;
            r_lane <= '0;
            r_tmo  <= '0;
        end else begin
            if (w_accept) begin
                r_tmo <= '0;
            end else if (w_ready) begin
                r_tmo <= r_tmo + c_tmo_w'(1);
            end

            if (w_accept && r_state == LEN_LO) r_len[7:0]  <= bus.byte_data;
            if (w_accept && r_state == LEN_HI) r_len[15:8] <= bus.byte_data;

            // Lane wraps 3 -> 0, so the next word always starts at lane 0.
            if (w_strobe) r_lane <= r_lane + LANE_W'(1);

            // Address/data are captured on the last byte and then held
            // until the next word completes; only rom_we qualifies them.
            if (w_word_full) begin
                r_addr  <= BASE_ADDR + (32'(r_idx) << 2);
                r_wdata <= w_word;
            end

            if (r_state == WRITE) r_idx <= r_idx + c_idx_w'(1);
        end
    end

    assign bus.byte_ready = w_ready;
    assign bus.rom_we     = w_we;
    assign bus.rom_addr   = r_addr;
    assign bus.rom_wdata  = r_wdata;

endmodule : rom_loader
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Self-checking bench for rom_loader. Stimulus pushes expected
//                ROM writes into a queue; an independent monitor pops and
//                compares on every rom_we. Status outputs are checked
//                directly at points where their value is known.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_loader;

    localparam int          ROM_WORDS      = 1024;
    localparam logic [31:0] BASE_ADDR      = 32'h0000_0000;
    localparam int          TIMEOUT_CYCLES = 16;

    // {busy, done, error, core_reset, core_enable, byte_ready}
    localparam logic [5:0] ST_IDLE  = 6'b000100;
    localparam logic [5:0] ST_LOAD  = 6'b100101;
    localparam logic [5:0] ST_DONE  = 6'b010010;
    localparam logic [5:0] ST_ERROR = 6'b001100;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic core_reset, core_enable, busy, done, error;

    rom_loader_if bif ();

    rom_loader #(
        .ROM_WORDS      (ROM_WORDS),
        .BASE_ADDR      (BASE_ADDR),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bif),
        .core_reset  (core_reset),
        .core_enable (core_enable),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string name, input logic [5:0] exp);
        check(name, {26'd0, busy, done, error, core_reset, core_enable, bif.byte_ready},
              {26'd0, exp});
    endtask

    // ------------------------------------------------------------- monitor
    wr_t mon_e;
    always @(negedge clk) begin
        if (bif.rom_we === 1'b1) begin
            check("ready_low_in_write", {31'd0, bif.byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write actual addr=%h data=%h required no write",
                         bif.rom_addr, bif.rom_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bif.rom_addr, mon_e.addr);
                check("wr_data", bif.rom_wdata, mon_e.data);
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    // All tasks start and end at a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        bif.byte_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Leaves byte_valid high so consecutive calls form a continuous stream.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        while (bif.byte_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            tests++;
            fails++;
            $display("FAIL send_timeout actual byte_ready=%b required 1 byte=%h", bif.byte_ready, b);
            bif.byte_valid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic send_hdr(input logic [15:0] len);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check_status("reset_status", ST_IDLE);
        check("reset_we",    {31'd0, bif.rom_we}, 32'd0);
        check("reset_addr",  bif.rom_addr,  BASE_ADDR);
        check("reset_wdata", bif.rom_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_status("idle_after_reset", ST_IDLE);

        // Basic two-word image
        pulse_start();
        check_status("len_lo_status", ST_LOAD);
        expect_wr(32'h0, 32'h0000_0013);
        expect_wr(32'h4, 32'h0010_0093);
        send_hdr(16'd2);
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        idle(1);
        check_status("done_two_words", ST_DONE);
        check_drained("drain_two_words");

        // Restart from DONE re-holds the core
        pulse_start();
        check_status("restart_from_done", ST_LOAD);

        // Zero-length header
        send_hdr(16'd0);
        check_status("len_zero_error", ST_ERROR);
        idle(5);
        check_status("error_sticky", ST_ERROR);

        // Recovery after error
        pulse_start();
        check_status("restart_from_error", ST_LOAD);
        expect_wr(32'h0, 32'hDEAD_BEEF);
        send_hdr(16'd1);
        send_word(32'hDEAD_BEEF);
        idle(1);
        check_status("done_after_recover", ST_DONE);
        check_drained("drain_recover");

        // Oversize header
        pulse_start();
        send_hdr(16'(ROM_WORDS + 1));
        check_status("len_oversize_error", ST_ERROR);
        idle(3);
        check_drained("drain_oversize");

        // Maximum legal image
        pulse_start();
        send_hdr(16'(ROM_WORDS));
        for (int i = 0; i < ROM_WORDS; i++) begin
            expect_wr(BASE_ADDR + 32'(i) * 32'd4, 32'hA500_0000 | 32'(i * 3));
            send_word(32'hA500_0000 | 32'(i * 3));
        end
        idle(1);
        check_status("done_max_len", ST_DONE);
        check_drained("drain_max_len");

        // Gaps below the timeout, including an accept on the terminal count
        pulse_start();
        expect_wr(32'h0, 32'h1122_3344);
        idle(TIMEOUT_CYCLES - 2); send_byte(8'h01);
        idle(TIMEOUT_CYCLES - 2); send_byte(8'h00);
        idle(TIMEOUT_CYCLES - 2); send_byte(8'h44);
        idle(TIMEOUT_CYCLES - 2); send_byte(8'h33);
        idle(TIMEOUT_CYCLES - 1); send_byte(8'h22);
        idle(TIMEOUT_CYCLES - 2); send_byte(8'h11);
        idle(1);
        check_status("done_with_gaps", ST_DONE);
        check_drained("drain_gaps");

        // Timeout mid-word: no write for the partial word
        pulse_start();
        send_hdr(16'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(TIMEOUT_CYCLES - 1);
        check_status("no_timeout_yet", ST_LOAD);
        idle(1);
        check_status("timeout_error", ST_ERROR);
        idle(3);
        check_drained("drain_timeout");

        // Asynchronous reset after word 1 of 3
        pulse_start();
        expect_wr(32'h0, 32'h4433_2211);
        send_hdr(16'd3);
        send_word(32'h4433_2211);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b0;
        #1;
        check_status("async_reset_status", ST_IDLE);
        check("async_reset_we",    {31'd0, bif.rom_we}, 32'd0);
        check("async_reset_addr",  bif.rom_addr,  BASE_ADDR);
        check("async_reset_wdata", bif.rom_wdata, 32'd0);
        @(negedge clk);
        reset          = 1'b1;
        bif.byte_valid = 1'b1;
        bif.byte_data  = 8'h77;
        repeat (4) @(negedge clk);
        check_status("idle_after_async_reset", ST_IDLE);
        check_drained("drain_async_reset");
        bif.byte_valid = 1'b0;
        @(negedge clk);

        // Continuous valid through WRITE cycles: counting pattern
        pulse_start();
        expect_wr(32'h0, 32'h0302_0100);
        expect_wr(32'h4, 32'h0706_0504);
        expect_wr(32'h8, 32'h0B0A_0908);
        expect_wr(32'hC, 32'h0F0E_0D0C);
        send_hdr(16'd4);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        idle(1);
        check_status("done_counting", ST_DONE);
        idle(2);
        check_drained("drain_counting");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rom_loader
`default_nettype wire
